// File: rtl/frame_dump_ctl.sv
// frame_dump_ctl: opens and closes a waveform-capture window. The window is
// opened either at a programmed frame number (mode 0) or a programmed number
// of clk cycles after a ROM download ends (mode 1). It is closed after a
// programmed number of frames, or by abort.
//
// state        | meaning
// -------------+------------------------------------------------------
// S_IDLE       | no sequence armed
// S_WAIT_DL    | armed in mode 1, waiting for the download to end
// S_HOLD       | post-download holdoff countdown running
// S_WAIT_FRAME | armed in mode 0, waiting for frame_cnt to hit start_frame
// S_DUMP       | capture window open
// S_DONE       | window closed after num_frames frames
//
// SYNC_STAGES must be 2 or 3.
module frame_dump_ctl #(
  parameter int HOLDOFF_W   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_vs,
  input  logic                 i_downloading,
  input  logic                 i_arm,
  input  logic                 i_abort,
  input  logic                 i_mode,
  input  logic [31:0]          i_start_frame,
  input  logic [15:0]          i_num_frames,
  input  logic [HOLDOFF_W-1:0] i_holdoff,
  output logic [31:0]          o_frame_cnt,
  output logic                 o_dump_en,
  output logic                 o_dump_start,
  output logic                 o_dump_stop,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_DL    = 3'd1,
    S_HOLD       = 3'd2,
    S_WAIT_FRAME = 3'd3,
    S_DUMP       = 3'd4,
    S_DONE       = 3'd5
  } state_t;

  localparam logic [HOLDOFF_W-1:0] LP_HOLD_ONE = HOLDOFF_W'(1);

  // synchronizers and falling-edge detection
  logic [SYNC_STAGES-1:0] r_vs_sync;
  logic [SYNC_STAGES-1:0] r_dl_sync;
  logic                   r_vs_prev;
  logic                   r_dl_prev;
  logic                   r_vs_fall;
  logic                   r_dl_fall;

  // frame counter and latched configuration
  logic [31:0]          r_frame_cnt;
  logic                 r_cfg_mode;
  logic [31:0]          r_cfg_start;
  logic [15:0]          r_cfg_num;
  logic [HOLDOFF_W-1:0] r_cfg_holdoff;

  // sequencer state
  state_t               r_state;
  logic [HOLDOFF_W-1:0] r_hold;
  logic [15:0]          r_wcnt;
  logic                 r_dump_en;
  logic                 r_dump_start;
  logic                 r_dump_stop;
  logic                 r_busy;
  logic                 r_done;

  // next-state signals
  state_t               w_state_nxt;
  logic [HOLDOFF_W-1:0] w_hold_nxt;
  logic [15:0]          w_wcnt_nxt;
  logic                 w_en_nxt;
  logic                 w_start_nxt;
  logic                 w_stop_nxt;
  logic                 w_cfg_load;
  logic [31:0]          w_frame_inc;
  logic [15:0]          w_wcnt_inc;

  assign w_frame_inc = r_frame_cnt + 32'd1;
  assign w_wcnt_inc  = r_wcnt + 16'd1;

  // Two-flop (or three) synchronizers; the fall flags are registered so each
  // is a clean one-cycle pulse SYNC_STAGES+1 cycles after the input edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs_sync <= '0;
      r_dl_sync <= '0;
      r_vs_prev <= 1'b0;
      r_dl_prev <= 1'b0;
      r_vs_fall <= 1'b0;
      r_dl_fall <= 1'b0;
    end else begin
      r_vs_sync <= {r_vs_sync[SYNC_STAGES-2:0], i_vs};
      r_dl_sync <= {r_dl_sync[SYNC_STAGES-2:0], i_downloading};
      r_vs_prev <= r_vs_sync[SYNC_STAGES-1];
      r_dl_prev <= r_dl_sync[SYNC_STAGES-1];
      r_vs_fall <= r_vs_prev & ~r_vs_sync[SYNC_STAGES-1];
      r_dl_fall <= r_dl_prev & ~r_dl_sync[SYNC_STAGES-1];
    end
  end

  // Free-running frame counter, counts in every state and wraps naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_cnt <= '0;
    end else if (r_vs_fall) begin
      r_frame_cnt <= w_frame_inc;
    end
  end

  // Configuration is frozen when a sequence is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cfg_mode    <= 1'b0;
      r_cfg_start   <= '0;
      r_cfg_num     <= '0;
      r_cfg_holdoff <= '0;
    end else if (w_cfg_load) begin
      r_cfg_mode    <= i_mode;
      r_cfg_start   <= i_start_frame;
      r_cfg_num     <= i_num_frames;
      r_cfg_holdoff <= i_holdoff;
    end
  end

  // Next-state and output decode; abort overrides everything else.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_wcnt_nxt  = r_wcnt;
    w_en_nxt    = r_dump_en;
    w_start_nxt = 1'b0;
    w_stop_nxt  = 1'b0;
    w_cfg_load  = 1'b0;

    if (i_abort) begin
      w_stop_nxt  = (r_state == S_DUMP);
      w_en_nxt    = 1'b0;
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_arm) begin
            w_cfg_load  = 1'b1;
            w_state_nxt = i_mode ? S_WAIT_DL : S_WAIT_FRAME;
          end
        end
        S_WAIT_DL: begin
          if (r_dl_fall) begin
            if (r_cfg_holdoff == '0) begin
              // zero holdoff: open on the cycle right after the fall
              w_state_nxt = S_DUMP;
              w_en_nxt    = 1'b1;
              w_start_nxt = 1'b1;
              w_wcnt_nxt  = '0;
            end else begin
              // one cycle of the holdoff is spent entering HOLD
              w_hold_nxt  = r_cfg_holdoff - LP_HOLD_ONE;
              w_state_nxt = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (r_hold == '0) begin
            w_state_nxt = S_DUMP;
            w_en_nxt    = 1'b1;
            w_start_nxt = 1'b1;
            w_wcnt_nxt  = '0;
          end else begin
            w_hold_nxt = r_hold - LP_HOLD_ONE;
          end
        end
        S_WAIT_FRAME: begin
          if (r_vs_fall && (w_frame_inc == r_cfg_start)) begin
            w_state_nxt = S_DUMP;
            w_en_nxt    = 1'b1;
            w_start_nxt = 1'b1;
            w_wcnt_nxt  = '0;
          end
        end
        S_DUMP: begin
          if (r_vs_fall) begin
            w_wcnt_nxt = w_wcnt_inc;
            if ((r_cfg_num != 16'd0) && (w_wcnt_inc == r_cfg_num)) begin
              w_state_nxt = S_DONE;
              w_en_nxt    = 1'b0;
              w_stop_nxt  = 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_en_nxt    = 1'b0;
        end
      endcase
    end
  end

  // State register and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_hold       <= '0;
      r_wcnt       <= '0;
      r_dump_en    <= 1'b0;
      r_dump_start <= 1'b0;
      r_dump_stop  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold       <= w_hold_nxt;
      r_wcnt       <= w_wcnt_nxt;
      r_dump_en    <= w_en_nxt;
      r_dump_start <= w_start_nxt;
      r_dump_stop  <= w_stop_nxt;
      r_busy       <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      r_done       <= (w_state_nxt == S_DONE);
    end
  end

  assign o_frame_cnt  = r_frame_cnt;
  assign o_dump_en    = r_dump_en;
  assign o_dump_start = r_dump_start;
  assign o_dump_stop  = r_dump_stop;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

  // r_cfg_mode is kept for visibility of the armed sequence; the mode itself
  // is consumed at arm time to pick the waiting state.
  logic w_unused;
  assign w_unused = r_cfg_mode;

endmodule

// File: doc/frame_dump_ctl.md
# frame_dump_ctl

Synthesizable sequencer that controls the waveform-capture window in the simulation and test harnesses. It counts video frames from the vertical-sync input and watches the ROM-download flag. Depending on the selected mode, it opens a capture window either at a programmed frame number or after a download completes, and closes it after a programmed number of frames. The `dump_en`, `dump_start` and `dump_stop` outputs drive the dump/probe logic and an on-chip logic-analyzer trigger.

## Interface
- `HOLDOFF_W`, 16: width of the post-download holdoff counter.
- `SYNC_STAGES`, 2: synchronizer depth for `vs` and `downloading`; legal values 2–3.
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `vs` input 1: vertical sync, active-high pulse, asynchronous to `clk`.
- `downloading` input 1: ROM download in progress, asynchronous to `clk`.
- `arm` input 1: single-cycle request to start a capture sequence.
- `abort` input 1: single-cycle request to stop the sequence and return to IDLE.
- `mode` input 1: 0 = frame trigger; 1 = download-end trigger.
- `start_frame` input 32: frame number that opens the window (mode 0).
- `num_frames` input 16: window length in frames; 0 = unlimited.
- `holdoff` input HOLDOFF_W: `clk` cycles to wait after the download falls (mode 1).
- `frame_cnt` output 32: frames counted since reset.
- `dump_en` output 1: high while the capture window is open.
- `dump_start` output 1: one-cycle pulse when the window opens.
- `dump_stop` output 1: one-cycle pulse when the window closes.
- `busy` output 1: high in any state other than IDLE or DONE.
- `done` output 1: high in the DONE state.

## Operation
- **Synchronization and edge detection.** `vs` and `downloading` each pass through SYNC_STAGES flops. A falling edge of the synchronized `vs` gives `vs_fall`; a falling edge of the synchronized `downloading` gives `dl_fall`.
- **Frame counter.** `frame_cnt` increments by 1 on every `vs_fall`, in all states. It wraps from 0xFFFFFFFF to 0.
- **Configuration capture.** `mode`, `start_frame`, `num_frames` and `holdoff` are latched on an accepted `arm`. Changes after that point have no effect on the running sequence.
- **States:** IDLE, WAIT_DL, HOLD, WAIT_FRAME, DUMP, DONE.
- **IDLE**
  - `arm` with mode 0 → WAIT_FRAME.
  - `arm` with mode 1 → WAIT_DL.
- **WAIT_DL.** On `dl_fall`, load the holdoff counter with `holdoff` and go to HOLD.
- **HOLD.** The counter decrements every cycle. When it reads 0 the window opens: go to DUMP. If `holdoff` = 0, the window opens on the cycle after `dl_fall`.
- **WAIT_FRAME.** On a `vs_fall` cycle where the value of `frame_cnt` after the increment equals `start_frame`, open the window and go to DUMP.
  - If `start_frame` ≤ `frame_cnt` when the sequence is armed, the sequence waits for the counter to wrap. This is intentional; no special case exists.
- **Opening the window.** Set `dump_en`, pulse `dump_start` for one cycle, and clear the window frame counter `wcnt` (16 bits).
- **DUMP**
  - Each `vs_fall` increments `wcnt`.
  - When `num_frames` ≠ 0 and `wcnt` reaches `num_frames`: clear `dump_en`, pulse `dump_stop`, go to DONE.
  - When `num_frames` = 0, the window stays open until `abort`.
  - A second `dl_fall` in DUMP is ignored.
- **DONE.** Holds until `arm` starts a new sequence (same transitions as IDLE) or `abort` returns to IDLE.
- **`arm` in WAIT_DL, HOLD, WAIT_FRAME or DUMP** is ignored.
- **`abort`** has priority over every other event in the same cycle.
  - From DUMP: clear `dump_en`, pulse `dump_stop`, go to IDLE.
  - From any other state: go to IDLE with no pulse.
- **Reset while asserted:** all outputs, `frame_cnt`, the synchronizers and the FSM return to 0 / IDLE immediately. No `dump_stop` pulse is generated, even if the window was open.

## Timing
- **Reset values:** `frame_cnt` = 0; `dump_en`, `dump_start`, `dump_stop`, `busy`, `done` = 0; state = IDLE.
- **`vs` latency.** An input edge produces `vs_fall` SYNC_STAGES+1 cycles later. `frame_cnt` updates on the cycle after `vs_fall`.
- **Mode 0 window open.** `dump_en` and `dump_start` rise in the same cycle that `frame_cnt` takes the value `start_frame`.
- **Mode 1 window open.** `dump_start` asserts `holdoff`+1 cycles after the `dl_fall` cycle.
- **Window close.** `dump_stop` and the fall of `dump_en` happen in the same cycle, registered from the terminating `vs_fall` or `abort`.
- **Pulse width.** `dump_start` and `dump_stop` are exactly one cycle wide. They are never both high in the same cycle.
- **Window length.** With `num_frames` = N, `dump_en` is high across exactly N `vs_fall` events, counting from the opening edge exclusive.
- **Simultaneous `arm` and `vs_fall` in IDLE:** the frame counter increments and the sequence is armed. The match comparison starts on the next `vs_fall`.
- **Outputs** are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Mode 0, `start_frame` = 5, `num_frames` = 3, arm at frame 0:**
  - `dump_start` fires when `frame_cnt` becomes 5.
  - `dump_stop` fires when `frame_cnt` becomes 8.
  - `done` = 1 afterwards.
- **Mode 1, `holdoff` = 10, `downloading` pulse 1→0:** `dump_start` occurs SYNC_STAGES+1+11 cycles after the input edge.
- **`num_frames` = 0:** `dump_en` stays high for 20 frames; then `abort` → `dump_stop` pulse and state IDLE.
- **Wrap-around:** force `frame_cnt` to 0xFFFFFFFE, `start_frame` = 1, arm → `frame_cnt` wraps through 0 and the window opens at 1.
- **`abort` and `vs_fall` in the same cycle as the terminating frame:** exactly one `dump_stop` pulse and the state is IDLE, not DONE.
- **`rst_n` low mid-DUMP:** all outputs go to 0 immediately with no `dump_stop`. After release, `frame_cnt` restarts from 0.
